bounce_generator: RTL and testbench
===================================

BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 SHALL have parameter CNT_W, default 4, meaning the width of the bounce-count configuration.
REQ-002 SHALL have parameter DUR_W, default 8, meaning the width of the segment-duration configuration.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the LFSR value loaded at reset; it must be nonzero.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port enable, input, 1 bit: 1 = bounce emulation active, 0 = bypass.
REQ-007 Port clean_in, input, 1 bit: clean level to be transmitted with emulated contact bounce.
REQ-008 Port cfg_bounce_cnt, input, CNT_W bits: number of glitch pairs per transition.
REQ-009 Port cfg_max_dur, input, DUR_W bits: mask applied to segment durations.
REQ-010 Port noisy_out, output, 1 bit: registered bouncing output, intended to drive a conditioner's noisy_in.
REQ-011 Port busy, output, 1 bit: high while state is BOUNCE or SETTLE.
REQ-012 Port bounce_done, output, 1 bit: one-cycle pulse when a transition has fully settled.

Function
REQ-013 SHALL keep an internal register `level` holding the last settled output value.
REQ-014 SHALL implement three states:
- IDLE: noisy_out = level; busy = 0.
- BOUNCE: emits alternating segments.
- SETTLE: holds the target value.
REQ-015 In IDLE with enable=1 and clean_in != level:
- latch target = clean_in, cnt = cfg_bounce_cnt, maxd = cfg_max_dur;
- drive noisy_out = target on the next edge;
- enter BOUNCE, or enter SETTLE directly if cnt == 0.
REQ-016 The output latency from the clean_in sampling edge to the first noisy_out change SHALL be exactly 1 cycle.
REQ-017 BOUNCE SHALL emit 2*cnt+1 segments alternating target, ~target, target, ..., ending on target.
REQ-018 Each non-final segment SHALL last d = 1 + (lfsr[DUR_W-1:0] & maxd) cycles, giving a range of 1..maxd+1.
REQ-019 The LFSR SHALL advance exactly once per non-final segment, at the segment start, and at no other time.
REQ-020 When the final target segment begins, the block SHALL enter SETTLE and hold noisy_out = target for maxd+1 cycles.
REQ-021 On the last SETTLE cycle the block SHALL:
- set level = target;
- pulse bounce_done for 1 cycle;
- return to IDLE, with busy falling in the same cycle.
REQ-022 Changes on clean_in during BOUNCE or SETTLE SHALL be ignored. On return to IDLE, a level still differing from `level` SHALL start a new event on the next cycle.
REQ-023 Configuration changes during BOUNCE or SETTLE SHALL have no effect on the event in progress.
REQ-024 With enable=0 the block SHALL:
- force IDLE;
- set level = clean_in and noisy_out = clean_in, with 1-cycle registered latency;
- hold busy = 0 and bounce_done = 0;
- not advance the LFSR.
REQ-025 enable falling mid-event SHALL abort the event on the next edge with no bounce_done pulse.
REQ-026 The duration counter SHALL be DUR_W+1 bits wide so that maxd = all-ones does not wrap.
REQ-027 The segment counter SHALL be CNT_W+1 bits wide so that 2*cnt+1 does not overflow.
REQ-028 The LFSR SHALL be a 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.

Reset
REQ-029 On reset the block SHALL set:
- state = IDLE;
- level = 0, noisy_out = 0, busy = 0, bounce_done = 0;
- lfsr = LFSR_SEED;
- all counters = 0.
REQ-030 Reset asserted mid-event SHALL abort the event at the next edge with no bounce_done pulse.

Structure
REQ-031 Package bounce_gen_pkg SHALL contain:
- the state enum (IDLE, BOUNCE, SETTLE);
- the LFSR width and tap constant;
- the default CNT_W and DUR_W.
REQ-032 The LFSR SHALL be a separate sub-module, bounce_lfsr, with ports clk, reset, advance and value[15:0].
REQ-033 The FSM, counters and output register SHALL reside in bounce_generator.

Verification
REQ-034 enable=1, cnt=0, maxd=0, clean_in 0->1:
- noisy_out=1 one cycle later;
- bounce_done pulses 1 cycle after that;
- no glitches occur.
REQ-035 cnt=3, maxd=0, clean_in 0->1:
- noisy_out = 1,0,1,0,1,0,1, one cycle each;
- then 1 settle cycle;
- bounce_done asserted;
- exactly 7 edges in total.
REQ-036 cnt=2, maxd=0x0F, seed 0xACE1: each segment length SHALL match a bit-accurate LFSR reference model, and the LFSR SHALL advance exactly 4 times.
REQ-037 clean_in toggles 1->0->1 during BOUNCE: the toggles are ignored; with clean_in ending at 1, no second event occurs. With clean_in ending at 0, a new event starts 1 cycle after bounce_done.
REQ-038 Reset asserted at the 3rd segment: next cycle noisy_out=0, busy=0, lfsr=0xACE1, and no bounce_done pulse.
REQ-039 enable=0, clean_in pulses 1 for 2 cycles: noisy_out mirrors the pulse with 1-cycle lag, busy stays 0, and the LFSR does not change.

Source files
------------

// File: rtl/bounce_gen_pkg.sv
// bounce_gen_pkg: shared states and constants for the contact-bounce emulator
package bounce_gen_pkg;
  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_e;
  localparam int LFSR_W = 16;
  // x^16+x^14+x^13+x^11+1 expressed as the bits XORed into bit 0
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_DUR_W = 8;
endpackage

// File: rtl/bounce_lfsr.sv
// bounce_lfsr: 16-bit Fibonacci LFSR, shifts left one step per advance
module bounce_lfsr
  import bounce_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  output logic [LFSR_W-1:0] value
);
  always_ff @(posedge clk)
    if (reset) value <= SEED;
    else if (advance) value <= {value[LFSR_W-2:0], ^(value & LFSR_TAPS)};
endmodule

// File: rtl/bounce_generator.sv
// bounce_generator: replays clean_in transitions on noisy_out with
// pseudo-random contact bounce, then settles and reports completion
module bounce_generator
  import bounce_gen_pkg::*;
#(
  parameter int          CNT_W     = DEF_CNT_W,
  parameter int          DUR_W     = DEF_DUR_W,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clean_in,
  input  logic [CNT_W-1:0] cfg_bounce_cnt,
  input  logic [DUR_W-1:0] cfg_max_dur,
  output logic             noisy_out,
  output logic             busy,
  output logic             bounce_done
);
  state_e             state_q;
  logic               level_q, target_q;
  logic [CNT_W:0]     seg_q;
  logic [DUR_W:0]     dur_q, rand_dur;
  logic [DUR_W-1:0]   maxd_q;
  logic [LFSR_W-1:0]  lfsr;
  logic               start, seg_end, last_seg, advance;
  assign start    = enable && state_q == IDLE && clean_in != level_q;
  assign seg_end  = state_q == BOUNCE && dur_q == '0;
  assign last_seg = seg_q == (CNT_W+1)'(1);
  // LFSR steps only when a non-final segment begins
  assign advance  = !reset && enable &&
                    ((start && cfg_bounce_cnt != '0) || (seg_end && !last_seg));
  assign rand_dur = (DUR_W+1)'(lfsr & LFSR_W'(start ? cfg_max_dur : maxd_q));
  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .advance(advance),
    .value  (lfsr)
  );
  // dur_q holds the remaining cycles of the current segment minus one
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      level_q     <= 1'b0;
      target_q    <= 1'b0;
      noisy_out   <= 1'b0;
      busy        <= 1'b0;
      bounce_done <= 1'b0;
      seg_q       <= '0;
      dur_q       <= '0;
      maxd_q      <= '0;
    end else if (!enable) begin
      state_q     <= IDLE;
      level_q     <= clean_in;
      noisy_out   <= clean_in;
      busy        <= 1'b0;
      bounce_done <= 1'b0;
    end else begin
      bounce_done <= 1'b0;
      case (state_q)
        IDLE:
          if (start) begin
            target_q  <= clean_in;
            maxd_q    <= cfg_max_dur;
            noisy_out <= clean_in;
            busy      <= 1'b1;
            if (cfg_bounce_cnt == '0) begin
              state_q <= SETTLE;
              dur_q   <= {1'b0, cfg_max_dur};
            end else begin
              state_q <= BOUNCE;
              seg_q   <= {cfg_bounce_cnt, 1'b0};
              dur_q   <= rand_dur;
            end
          end else noisy_out <= level_q;
        BOUNCE:
          if (dur_q != '0) dur_q <= dur_q - 1'b1;
          else if (last_seg) begin
            state_q   <= SETTLE;
            noisy_out <= target_q;
            dur_q     <= {1'b0, maxd_q};
          end else begin
            noisy_out <= ~noisy_out;
            seg_q     <= seg_q - 1'b1;
            dur_q     <= rand_dur;
          end
        SETTLE:
          if (dur_q != '0) dur_q <= dur_q - 1'b1;
          else begin
            state_q     <= IDLE;
            level_q     <= target_q;
            busy        <= 1'b0;
            bounce_done <= 1'b1;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bounce_generator.sv
// tb_bounce_generator: directed checks of bounce timing, bypass, reset abort
module tb_bounce_generator;
  logic       clk = 1'b0;
  logic       reset, enable, clean_in;
  logic [3:0] cfg_bounce_cnt;
  logic [7:0] cfg_max_dur;
  logic       noisy_out, busy, bounce_done;
  int         n_chk = 0, n_pass = 0;
  logic [15:0] lfsr_m;
  logic       exp_q[$];
  logic       prev;
  int         edges, d;
  always #5 clk = ~clk;
  bounce_generator dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .clean_in      (clean_in),
    .cfg_bounce_cnt(cfg_bounce_cnt),
    .cfg_max_dur   (cfg_max_dur),
    .noisy_out     (noisy_out),
    .busy          (busy),
    .bounce_done   (bounce_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  initial begin
    reset = 1'b1; enable = 1'b1; clean_in = 1'b0; cfg_bounce_cnt = 4'd0; cfg_max_dur = 8'd0;
    step; step;
    check("rst_noisy", noisy_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", bounce_done, 0);
    check("rst_lfsr", dut.u_lfsr.value, 16'hACE1);
    reset = 1'b0;
    step;
    check("idle_busy", busy, 0);
    // zero bounces, zero settle extension
    clean_in = 1'b1;
    step;
    check("c0_noisy", noisy_out, 1);
    check("c0_busy", busy, 1);
    check("c0_nodone", bounce_done, 0);
    step;
    check("c0_done", bounce_done, 1);
    check("c0_busy_fall", busy, 0);
    check("c0_hold", noisy_out, 1);
    step;
    check("c0_done_once", bounce_done, 0);
    check("c0_lfsr", dut.u_lfsr.value, 16'hACE1);
    // bypass mirrors clean_in one cycle late
    enable = 1'b0; clean_in = 1'b0;
    step;
    check("byp_low", noisy_out, 0);
    clean_in = 1'b1;
    step;
    check("byp_hi1", noisy_out, 1);
    check("byp_busy", busy, 0);
    step;
    check("byp_hi2", noisy_out, 1);
    clean_in = 1'b0;
    step;
    check("byp_fall", noisy_out, 0);
    check("byp_done", bounce_done, 0);
    check("byp_lfsr", dut.u_lfsr.value, 16'hACE1);
    // three glitch pairs, one-cycle segments
    enable = 1'b1; cfg_bounce_cnt = 4'd3; cfg_max_dur = 8'd0; clean_in = 1'b1;
    edges = 0; prev = noisy_out;
    for (int i = 0; i < 7; i++) begin
      step;
      check($sformatf("c3_seg%0d", i), noisy_out, (i % 2 == 0) ? 1 : 0);
      if (noisy_out != prev) edges++;
      prev = noisy_out;
    end
    check("c3_busy", busy, 1);
    step;
    check("c3_done", bounce_done, 1);
    check("c3_final", noisy_out, 1);
    check("c3_edges", edges, 7);
    lfsr_m = 16'hACE1;
    for (int i = 0; i < 6; i++) lfsr_m = lfsr_next(lfsr_m);
    check("c3_lfsr", dut.u_lfsr.value, lfsr_m);
    // random segment lengths against the model, with mid-event config and input churn
    reset = 1'b1;
    step;
    reset = 1'b0; cfg_bounce_cnt = 4'd2; cfg_max_dur = 8'h0F; clean_in = 1'b1;
    lfsr_m = 16'hACE1;
    for (int s = 0; s < 4; s++) begin
      d = 1 + int'(lfsr_m[3:0]);
      lfsr_m = lfsr_next(lfsr_m);
      repeat (d) exp_q.push_back(s % 2 == 0);
    end
    repeat (16) exp_q.push_back(1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      step;
      if (i == 0) begin cfg_bounce_cnt = 4'd7; cfg_max_dur = 8'd0; end
      if (i == 2) clean_in = 1'b0;
      if (i == 4) clean_in = 1'b1;
      check($sformatf("rnd_cyc%0d", i), noisy_out, exp_q[i]);
    end
    step;
    check("rnd_done", bounce_done, 1);
    check("rnd_busy", busy, 0);
    check("rnd_lfsr", dut.u_lfsr.value, lfsr_m);
    step; step; step;
    check("rnd_no_event", busy, 0);
    check("rnd_level", noisy_out, 1);
    // clean_in returns to a differing level while busy: restart after done
    cfg_bounce_cnt = 4'd1; cfg_max_dur = 8'd0; clean_in = 1'b0;
    step;
    check("rs_seg0", noisy_out, 0);
    clean_in = 1'b1;
    step;
    check("rs_seg1", noisy_out, 1);
    step;
    check("rs_seg2", noisy_out, 0);
    step;
    check("rs_done", bounce_done, 1);
    check("rs_busy_fall", busy, 0);
    check("rs_level", noisy_out, 0);
    step;
    check("rs_restart", busy, 1);
    check("rs_restart_out", noisy_out, 1);
    check("rs_restart_nodone", bounce_done, 0);
    for (int k = 0; k < 50 && !bounce_done; k++) step;
    check("rs_wait_done", bounce_done, 1);
    // reset during the third segment
    enable = 1'b0; clean_in = 1'b0;
    step;
    enable = 1'b1; cfg_bounce_cnt = 4'd3; cfg_max_dur = 8'd0; clean_in = 1'b1;
    step;
    check("ra_seg1", noisy_out, 1);
    step;
    check("ra_seg2", noisy_out, 0);
    step;
    check("ra_seg3", noisy_out, 1);
    reset = 1'b1;
    step;
    check("ra_noisy", noisy_out, 0);
    check("ra_busy", busy, 0);
    check("ra_lfsr", dut.u_lfsr.value, 16'hACE1);
    check("ra_done", bounce_done, 0);
    reset = 1'b0; clean_in = 1'b0;
    step;
    check("ra_done2", bounce_done, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
